// File: rtl/apb_master_arbiter_if.sv
// rtl/apb_master_arbiter_if.sv - requester-side and APB-side signal bundle for apb_master_arbiter
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int NUM_SLV = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic [31:0]           paddr;
  logic                  pwrite;
  logic [31:0]           pwdata;
  logic                  penable;
  logic [NUM_SLV-1:0]    pselx;
  logic [NUM_SLV*32-1:0] prdata;
  logic [NUM_SLV-1:0]    pready;
  logic [NUM_SLV-1:0]    pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, penable, pselx
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, paddr, pwrite, pwdata, penable, pselx
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - round-robin multi-requester APB master with address decode and timeout
module apb_master_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_SLV   = 2,
  parameter int SLV_SHIFT = 10,
  parameter int TIMEOUT   = 16
) (
  input  logic                 pclk_i,
  input  logic                 preset_i,
  apb_master_arbiter_if.master bus
);
  localparam int SIDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int RIDX_W = $clog2(NUM_REQ);
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  state_e             state_q;
  logic [RIDX_W-1:0]  rr_q;
  logic [RIDX_W-1:0]  gnt_q;
  logic [SIDX_W-1:0]  sidx_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rdata_q;
  logic               write_q;
  logic               err_q;
  logic               penable_q;
  logic [NUM_SLV-1:0] psel_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [WCNT_W-1:0]  wait_q;

  logic               gnt_found_d;
  logic [RIDX_W-1:0]  gnt_idx_d;
  logic [RIDX_W-1:0]  rr_d;
  logic [31:0]        sel_addr_d;
  logic [31:0]        sel_wdata_d;
  logic               sel_write_d;
  logic               dec_err_d;
  logic               pready_sel;
  logic               pslverr_sel;
  logic [31:0]        prdata_sel;

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    gnt_found_d = 1'b0;
    gnt_idx_d   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        gnt_found_d = 1'b1;
        gnt_idx_d   = RIDX_W'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_addr_d  = bus.req_addr[32*int'(gnt_idx_d) +: 32];
  assign sel_wdata_d = bus.req_wdata[32*int'(gnt_idx_d) +: 32];
  assign sel_write_d = bus.req_write[gnt_idx_d];
  assign rr_d        = (gnt_idx_d == RIDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_d + 1'b1;
  // The whole region number above SLV_SHIFT is decoded, so windows past the last slave error out.
  assign dec_err_d   = (sel_addr_d >> SLV_SHIFT) >= 32'(NUM_SLV);

  assign pready_sel  = bus.pready[sidx_q];
  assign pslverr_sel = bus.pslverr[sidx_q];
  assign prdata_sel  = bus.prdata[32*int'(sidx_q) +: 32];

  assign bus.req_ready = (state_q == IDLE && gnt_found_d && !preset_i)
                         ? (NUM_REQ'(1) << gnt_idx_d) : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.paddr     = addr_q;
  assign bus.pwrite    = write_q;
  assign bus.pwdata    = wdata_q;
  assign bus.penable   = penable_q;
  assign bus.pselx     = psel_q;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      gnt_q       <= '0;
      sidx_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      penable_q   <= 1'b0;
      psel_q      <= '0;
      rsp_valid_q <= '0;
      wait_q      <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_found_d) begin
            gnt_q   <= gnt_idx_d;
            rr_q    <= rr_d;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            write_q <= sel_write_d;
            sidx_q  <= sel_addr_d[SLV_SHIFT +: SIDX_W];
            wait_q  <= '0;
            if (dec_err_d) begin
              rdata_q     <= '0;
              err_q       <= 1'b1;
              rsp_valid_q <= NUM_REQ'(1) << gnt_idx_d;
              state_q     <= RESP;
            end else begin
              psel_q  <= NUM_SLV'(1) << sel_addr_d[SLV_SHIFT +: SIDX_W];
              state_q <= SETUP;
            end
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= WCNT_W'(1);
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready_sel) begin
            rdata_q     <= (write_q || pslverr_sel) ? '0 : prdata_sel;
            err_q       <= pslverr_sel;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << gnt_q;
            state_q     <= RESP;
          end else if (wait_q == WCNT_W'(TIMEOUT)) begin
            rdata_q     <= '0;
            err_q       <= 1'b1;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            rsp_valid_q <= NUM_REQ'(1) << gnt_q;
            state_q     <= RESP;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed scoreboard bench for apb_master_arbiter
module tb_apb_master_arbiter;
  localparam int NUM_REQ = 4;
  localparam int NUM_SLV = 2;

  typedef struct {
    int          idx;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  apb_master_arbiter_if #(.NUM_REQ(NUM_REQ), .NUM_SLV(NUM_SLV)) bus ();

  apb_master_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_SLV(NUM_SLV), .SLV_SHIFT(10), .TIMEOUT(16)
  ) dut (
    .pclk_i  (pclk),
    .preset_i(preset),
    .bus     (bus)
  );

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Slave bank; unselected slaves drive ready/error/garbage data that must be ignored
  int          slv_wait  [NUM_SLV];
  logic [31:0] slv_rdata [NUM_SLV];
  logic        slv_err   [NUM_SLV];
  logic        slv_dead  [NUM_SLV];
  logic [4:0]  acnt = '0;
  always @(posedge pclk) acnt <= bus.penable ? acnt + 5'd1 : 5'd0;

  always_comb begin
    bus.pready  = '0;
    bus.pslverr = '0;
    bus.prdata  = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (bus.pselx[s]) begin
        bus.pready[s]          = bus.penable && !slv_dead[s] && (int'(acnt) == slv_wait[s]);
        bus.pslverr[s]         = slv_err[s];
        bus.prdata[32*s +: 32] = slv_rdata[s];
      end else begin
        bus.pready[s]          = 1'b1;
        bus.pslverr[s]         = 1'b1;
        bus.prdata[32*s +: 32] = 32'hBAD0_0000 + 32'(s);
      end
    end
  end

  int          checks = 0;
  int          errors = 0;
  rsp_t        sb[$];
  int          acc_log[$];
  int          acc_cyc[$];
  logic [31:0] exp_rd [NUM_REQ];
  logic        exp_er [NUM_REQ];
  int          acc_at;
  int          rsp_cyc;
  bit          rsp_seen;
  bit          psel_seen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge pclk);
    #1;
  endtask

  task automatic sample();
    rsp_t e;
    @(negedge pclk);
    if (bus.pselx != 0) psel_seen = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (bus.req_ready[r]) begin
        sb.push_back('{r, exp_rd[r], exp_er[r]});
        acc_log.push_back(r);
        acc_cyc.push_back(cyc);
      end
    end
    if (bus.rsp_valid != 0) begin
      rsp_seen = 1'b1;
      rsp_cyc  = cyc;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(bus.rsp_valid), 64'h0);
      end else begin
        e = sb.pop_front();
        check("rsp_onehot", 64'(bus.rsp_valid), 64'(1 << e.idx));
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
      end
    end
  endtask

  task automatic do_req(input int r, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic er);
    int n;
    exp_rd[r] = rd;
    exp_er[r] = er;
    bus.req_valid[r]           = 1'b1;
    bus.req_write[r]           = wr;
    bus.req_addr[32*r +: 32]   = a;
    bus.req_wdata[32*r +: 32]  = d;
    acc_log.delete();
    acc_cyc.delete();
    rsp_seen = 1'b0;
    n = 0;
    sample();
    while (acc_log.size() == 0 && n < 20) begin
      nxt();
      sample();
      n++;
    end
    check("accept_idx", (acc_log.size() == 1) ? 64'(acc_log[0]) : 64'hEE, 64'(r));
    acc_at = cyc;
    nxt();
    bus.req_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lat);
    int n = 0;
    sample();
    while (!rsp_seen && n < 40) begin
      nxt();
      sample();
      n++;
    end
    check(tag, rsp_seen ? 64'(rsp_cyc - acc_at) : 64'hFFFF, 64'(lat));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      sample();
      nxt();
      n++;
    end
    check(tag, 64'(sb.size()), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    preset        = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      slv_wait[s]  = 0;
      slv_rdata[s] = 32'h0;
      slv_err[s]   = 1'b0;
      slv_dead[s]  = 1'b0;
    end
    for (int r = 0; r < NUM_REQ; r++) begin
      exp_rd[r] = '0;
      exp_er[r] = 1'b0;
    end

    // Reset state
    nxt();
    nxt();
    sample();
    check("rst_pselx", 64'(bus.pselx), 64'h0);
    check("rst_penable", 64'(bus.penable), 64'h0);
    check("rst_paddr", 64'(bus.paddr), 64'h0);
    check("rst_pwdata", 64'(bus.pwdata), 64'h0);
    check("rst_pwrite", 64'(bus.pwrite), 64'h0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
    check("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
    nxt();
    preset = 1'b0;

    // Zero-wait write to slave0
    slv_rdata[0] = 32'h1111_2222;
    do_req(0, 1'b1, 32'h0000_0004, 32'hA5A5_0001, 32'h0, 1'b0);
    sample();
    check("t1_setup_pselx", 64'(bus.pselx), 64'h1);
    check("t1_setup_penable", 64'(bus.penable), 64'h0);
    check("t1_paddr", 64'(bus.paddr), 64'h4);
    check("t1_pwrite", 64'(bus.pwrite), 64'h1);
    check("t1_pwdata", 64'(bus.pwdata), 64'hA5A5_0001);
    nxt();
    sample();
    check("t1_access_pselx", 64'(bus.pselx), 64'h1);
    check("t1_access_penable", 64'(bus.penable), 64'h1);
    nxt();
    wait_rsp("t1_latency", 3);
    check("t1_resp_pselx", 64'(bus.pselx), 64'h0);
    nxt();

    // Read from slave1 with 3 wait states
    slv_wait[1]  = 3;
    slv_rdata[1] = 32'hDEAD_BEEF;
    do_req(1, 1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, 1'b0);
    wait_rsp("t2_latency", 6);
    nxt();

    // Slave error on a zero-wait read: rdata forced to 0
    slv_wait[1] = 0;
    slv_err[1]  = 1'b1;
    do_req(0, 1'b0, 32'h0000_0408, 32'h0, 32'h0, 1'b1);
    wait_rsp("slverr_latency", 3);
    nxt();
    slv_err[1] = 1'b0;

    // Decode error: no select ever raised
    psel_seen = 1'b0;
    do_req(2, 1'b0, 32'h0000_0800, 32'h0, 32'h0, 1'b1);
    wait_rsp("t4_latency", 1);
    check("t4_no_psel", 64'(psel_seen), 64'h0);
    nxt();

    // Slave0 never ready: timeout after 16 ACCESS cycles
    slv_dead[0] = 1'b1;
    do_req(3, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b1);
    wait_rsp("t5_latency", 18);
    check("t5_idle_pselx", 64'(bus.pselx), 64'h0);
    check("t5_idle_penable", 64'(bus.penable), 64'h0);
    nxt();
    slv_dead[0] = 1'b0;

    // All requesters held from reset: strict round robin
    preset = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      exp_rd[r]                  = '0;
      exp_er[r]                  = 1'b0;
      bus.req_write[r]           = 1'b1;
      bus.req_addr[32*r +: 32]   = 32'(4 * r);
      bus.req_wdata[32*r +: 32]  = 32'h5000_0000 + 32'(r);
    end
    bus.req_valid = '1;
    nxt();
    nxt();
    preset = 1'b0;
    acc_log.delete();
    acc_cyc.delete();
    for (int n = 0; n < 40 && acc_log.size() < 5; n++) begin
      sample();
      nxt();
    end
    bus.req_valid = '0;
    check("rr_grants", 64'(acc_log.size()), 64'h5);
    if (acc_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check("rr_order", 64'(acc_log[i]), 64'(i % NUM_REQ));
      for (int i = 1; i < 5; i++) check("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'h4);
    end
    drain("rr_drain");

    // Reset during ACCESS: transfer aborted silently, pointer back to 0
    slv_wait[0] = 5;
    do_req(1, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0);
    sample();
    nxt();
    sample();
    check("t6_in_access", 64'(bus.penable), 64'h1);
    nxt();
    preset = 1'b1;
    sample();
    nxt();
    preset = 1'b0;
    sample();
    check("t6_pselx", 64'(bus.pselx), 64'h0);
    check("t6_penable", 64'(bus.penable), 64'h0);
    check("t6_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    check("t6_paddr", 64'(bus.paddr), 64'h0);
    sb.delete();
    for (int n = 0; n < 8; n++) begin
      nxt();
      sample();
    end
    nxt();
    slv_wait[0] = 0;
    exp_rd[0] = '0;
    exp_er[0] = 1'b0;
    exp_rd[3] = '0;
    exp_er[3] = 1'b0;
    bus.req_addr[0 +: 32]  = 32'h0000_000C;
    bus.req_addr[96 +: 32] = 32'h0000_0014;
    bus.req_valid = 4'b1001;
    sample();
    check("t6_first_grant", 64'(bus.req_ready), 64'h1);
    nxt();
    bus.req_valid = '0;
    drain("t6_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
